score_sequencer: RTL and testbench
==================================

Name: score_sequencer

Overview:
- Plays a stored melody by stepping through a score memory of 16-bit note words. For each note it drives a pitch code to the tone generator and a beat code to the existing beat decoder.
- The beat decoder combinationally returns the note duration in clk cycles. The sequencer counts that duration, then inserts a short muted articulation gap and fetches the next note.
- Sits between the AHB music-control register slave (start/stop/pause/loop) and the buzzer tone generator.

Parameters:
- ADDR_W, 8, score memory address width (up to 256 notes)
- GAP_CYCLES, 28'd2500000, muted gap after each note (50 ms at 50 MHz); 0 means no gap
- END_WORD, 16'hFFFF, end-of-score marker

Ports:
- clk  input  1  system clock (50 MHz)
- RSTn  input  1  synchronous active-low reset
- start  input  1  single-cycle pulse: begin playback at base_addr
- stop  input  1  single-cycle pulse: abort playback and go idle
- pause  input  1  level: freeze the duration/gap counter and mute
- loop_en  input  1  level: on END_WORD, restart at base_addr instead of finishing
- base_addr  input  ADDR_W  first note address, sampled on start
- mem_addr  output  ADDR_W  score memory read address
- mem_rd  output  1  read strobe; data is valid exactly 1 cycle later
- mem_rdata  input  16  note word: [15:12] beat code, [11:8] reserved, [7:0] pitch code
- beat  output  4  beat code to the beat decoder (registered)
- beat_cnt_parameter  input  28  duration in cycles from the beat decoder
- pitch  output  8  pitch code to the tone generator; 0 means silence
- tone_en  output  1  tone generator enable
- busy  output  1  high in every state except IDLE
- done  output  1  single-cycle pulse when a non-looping score ends
- note_idx  output  ADDR_W  address of the note currently playing

Behaviour:
- Reset (RSTn low at a clk edge) forces:
  - state IDLE
  - all outputs 0: mem_addr, mem_rd, beat, pitch, tone_en, busy, done, note_idx
  - internal counter 0
- Reset mid-note stops the tone on the next edge.
- State machine (one-hot or encoded, designer's choice):
  - IDLE: on start, latch mem_addr = base_addr, go to FETCH.
  - FETCH: mem_rd = 1 for one cycle, then go to WAIT.
  - WAIT: the memory returns data; capture mem_rdata into the note register, then go to DECODE.
  - DECODE: if the note word == END_WORD:
    - with loop_en = 1, set mem_addr = base_addr and go to FETCH;
    - otherwise pulse done and go to IDLE.
  - DECODE (not END_WORD): drive beat = word[15:12] and let the decoder settle this cycle, then go to LOAD.
  - LOAD: if beat_cnt_parameter == 0 (illegal beat code > 6), skip the note: mem_addr + 1, go to FETCH. Otherwise:
    - counter = beat_cnt_parameter - 1
    - pitch = word[7:0], note_idx = mem_addr
    - tone_en = 1 if pitch != 0 (a rest plays silence for its full duration)
    - go to PLAY.
  - PLAY: decrement the counter each cycle. At 0: tone_en = 0, pitch = 0, then:
    - GAP_CYCLES > 0: load counter = GAP_CYCLES - 1, go to GAP;
    - GAP_CYCLES == 0: increment mem_addr, go to FETCH.
  - GAP: decrement the counter. At 0, increment mem_addr and go to FETCH.
- Timing:
  - A note of duration D plays with tone_en high for exactly D cycles.
  - Note-to-note period is D + GAP_CYCLES + 4 cycles (FETCH, WAIT, DECODE, LOAD).
- Address wrap: mem_addr increments modulo 2^ADDR_W. There is no implicit end at the top of memory.
- pause, in PLAY/GAP: the counter holds and tone_en is forced 0. pitch is retained and tone_en is restored on release.
- pause in other states: ignored; the fetch completes and the block holds at the entry of PLAY.
- stop has priority over everything except reset. On the next edge: IDLE, tone_en = 0, pitch = 0, no done pulse.
- start while busy is ignored.
- If start and stop arrive in the same cycle, stop wins.
- done: single-cycle pulse, asserted on the DECODE -> IDLE transition only.

Decomposition:
- Shared package music_pkg holds:
  - state encoding
  - note-word field positions (BEAT_MSB/LSB, PITCH_MSB/LSB)
  - END_WORD
  - beat code constants 0..6 (whole..sixty-fourth), shared with the beat decoder
- One natural sub-module: note_timer — a 28-bit loadable down-counter with load, enable (= !pause) and zero flag. It is used for both PLAY and GAP.
- The beat decoder stays external. The bench may drive beat_cnt_parameter directly with small values.

Test Plan:
- Basic playback: score {0x0140, 0x2041, END_WORD}, base_addr 0, GAP_CYCLES 3, bench decoder maps beat 0 -> 10 and beat 2 -> 5.
  - pitch 0x40 with tone_en high for 10 cycles, 3 muted cycles, then pitch 0x41 for 5 cycles.
  - done pulses once; busy falls the same cycle.
- Loop: same score with loop_en = 1 -> after note 1, mem_addr returns to 0 and pitch 0x40 replays; done never asserts.
- Illegal beat and rest:
  - word 0x7040 (parameter 0) is skipped with no tone_en cycle;
  - word 0x0100 plays 10 cycles with tone_en low and busy high.
- Pause: assert pause for 7 cycles at counter = 4 -> tone_en low for those 7 cycles; total tone_en-high cycles for the note is still 10.
- Stop and reset mid-note:
  - stop at PLAY cycle 3 -> next edge IDLE, tone_en = 0, no done pulse;
  - separately, RSTn low during GAP -> all outputs 0 next edge; a subsequent start replays from base_addr.
- Wrap and start/stop collision:
  - base_addr 0xFF with the next note at 0x00 -> fetch order 0xFF, then 0x00;
  - start and stop in the same cycle from IDLE -> remains IDLE.

Source files
------------

// File: rtl/music_pkg.sv
// music_pkg
//   Definitions shared by the score sequencer, its note timer and the
//   external beat decoder:
//   - sequencer state encoding
//   - note-word field positions: [15:12] beat code, [11:8] reserved,
//     [7:0] pitch code
//   - end-of-score marker
//   - beat code constants, whole note through sixty-fourth note
//   - helpers that extract the beat and pitch fields from a note word
package music_pkg;

  localparam int NOTE_W  = 16;
  localparam int TIMER_W = 28;

  localparam int BEAT_MSB  = 15;
  localparam int BEAT_LSB  = 12;
  localparam int PITCH_MSB = 7;
  localparam int PITCH_LSB = 0;

  localparam logic [NOTE_W-1:0] END_WORD = 16'hFFFF;

  // Beat codes understood by the beat decoder. Codes above 6 are illegal,
  // and the decoder reports a zero duration for them.
  localparam logic [3:0] BEAT_WHOLE        = 4'd0;
  localparam logic [3:0] BEAT_HALF         = 4'd1;
  localparam logic [3:0] BEAT_QUARTER      = 4'd2;
  localparam logic [3:0] BEAT_EIGHTH       = 4'd3;
  localparam logic [3:0] BEAT_SIXTEENTH    = 4'd4;
  localparam logic [3:0] BEAT_THIRTYSECOND = 4'd5;
  localparam logic [3:0] BEAT_SIXTYFOURTH  = 4'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_DECODE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP
  } seq_state_e;

  function automatic logic [3:0] note_beat(input logic [NOTE_W-1:0] word);
    return word[BEAT_MSB:BEAT_LSB];
  endfunction

  function automatic logic [7:0] note_pitch(input logic [NOTE_W-1:0] word);
    return word[PITCH_MSB:PITCH_LSB];
  endfunction

endpackage

// File: rtl/note_timer.sv
// note_timer
//   This is a loadable 28-bit down-counter that times both the sounding
//   part of a note and the muted gap that follows it.
//   Ports:
//     clk      - system clock
//     RSTn     - synchronous active-low reset, which clears the count
//     load     - load load_val on the next edge (takes priority over en)
//     load_val - value to load
//     en       - count down by one per cycle; the count stops at zero
//     zero     - high while the count is zero
module note_timer
  import music_pkg::*;
(
  input  logic               clk,
  input  logic               RSTn,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               en,
  output logic               zero
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  // The count saturates at zero. The sequencer leaves PLAY/GAP on zero, so
  // it never relies on the count wrapping.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!RSTn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/score_sequencer.sv
// score_sequencer
//   This block plays a stored melody. It steps through score memory one
//   note word at a time. For each note it:
//   - sends the beat code to the external beat decoder
//   - times the duration that the decoder returns
//   - drives the pitch to the tone generator
//   - then waits out a muted articulation gap before it fetches the next
//     note
//   Ports:
//     clk, RSTn          - clock and synchronous active-low reset
//     start / stop       - one-cycle control pulses; stop has priority
//     pause              - level; freezes PLAY/GAP timing and mutes the tone
//     loop_en            - level; at the end marker, restart at base_addr
//     base_addr          - first note address, latched on start
//     mem_addr, mem_rd   - score memory read port; data arrives 1 cycle later
//     mem_rdata          - note word from score memory
//     beat               - registered beat code to the beat decoder
//     beat_cnt_parameter - decoded note duration in cycles (0 = illegal)
//     pitch, tone_en     - tone generator interface
//     busy, done         - status: busy outside IDLE, done pulses when the
//                          score ends and looping is off
//     note_idx           - address of the note that is playing
module score_sequencer #(
  parameter int          ADDR_W     = 8,
  parameter logic [27:0] GAP_CYCLES = 28'd2500000,
  parameter logic [15:0] END_WORD   = music_pkg::END_WORD
) (
  input  logic              clk,
  input  logic              RSTn,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [15:0]       mem_rdata,
  output logic [3:0]        beat,
  input  logic [27:0]       beat_cnt_parameter,
  output logic [7:0]        pitch,
  output logic              tone_en,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] note_idx
);

  import music_pkg::*;

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] note_idx_q, note_idx_d;
  logic [15:0]       note_q, note_d;
  logic [3:0]        beat_q, beat_d;
  logic [7:0]        pitch_q, pitch_d;
  logic              tone_q, tone_d;
  logic              done_q, done_d;

  logic              timer_load;
  logic [27:0]       timer_val;
  logic              timer_en;
  logic              timer_zero;
  logic              timing_state;

  note_timer u_timer (
    .clk      (clk),
    .RSTn     (RSTn),
    .load     (timer_load),
    .load_val (timer_val),
    .en       (timer_en),
    .zero     (timer_zero)
  );

  assign timing_state = (state_q == ST_PLAY) || (state_q == ST_GAP);

  // State register: every flop in the sequencer.
  always_ff @(posedge clk) begin
    if (!RSTn) begin
      state_q    <= ST_IDLE;
      mem_addr_q <= '0;
      base_q     <= '0;
      note_idx_q <= '0;
      note_q     <= '0;
      beat_q     <= '0;
      pitch_q    <= '0;
      tone_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      base_q     <= base_d;
      note_idx_q <= note_idx_d;
      note_q     <= note_d;
      beat_q     <= beat_d;
      pitch_q    <= pitch_d;
      tone_q     <= tone_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic. stop overrides every state and silences the tone
  // without a done pulse. base_addr is latched at start so that a looping
  // score restarts where it began, even if base_addr changes later.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    base_d     = base_q;
    note_idx_d = note_idx_q;
    note_d     = note_q;
    beat_d     = beat_q;
    pitch_d    = pitch_q;
    tone_d     = tone_q;
    done_d     = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
      pitch_d = '0;
      tone_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            base_d     = base_addr;
            mem_addr_d = base_addr;
            state_d    = ST_FETCH;
          end
        end
        ST_FETCH: begin
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          note_d  = mem_rdata;
          state_d = ST_DECODE;
        end
        ST_DECODE: begin
          if (note_q == END_WORD) begin
            if (loop_en) begin
              mem_addr_d = base_q;
              state_d    = ST_FETCH;
            end else begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            beat_d  = note_beat(note_q);
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          // A zero duration marks an illegal beat code, so the note is skipped.
          if (beat_cnt_parameter == '0) begin
            mem_addr_d = mem_addr_q + ADDR_W'(1);
            state_d    = ST_FETCH;
          end else begin
            pitch_d    = note_pitch(note_q);
            note_idx_d = mem_addr_q;
            tone_d     = (note_pitch(note_q) != 8'h00);
            state_d    = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (!pause && timer_zero) begin
            tone_d  = 1'b0;
            pitch_d = '0;
            if (GAP_CYCLES != '0) begin
              state_d = ST_GAP;
            end else begin
              mem_addr_d = mem_addr_q + ADDR_W'(1);
              state_d    = ST_FETCH;
            end
          end
        end
        ST_GAP: begin
          if (!pause && timer_zero) begin
            mem_addr_d = mem_addr_q + ADDR_W'(1);
            state_d    = ST_FETCH;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output logic and timer control. Each timer load is one less than the
  // number of cycles to time, because the final cycle is the one in which
  // the count reads zero.
  always_comb begin
    timer_load = 1'b0;
    timer_val  = '0;
    if (!stop && (state_q == ST_LOAD) && (beat_cnt_parameter != '0)) begin
      timer_load = 1'b1;
      timer_val  = beat_cnt_parameter - 28'd1;
    end else if (!stop && (state_q == ST_PLAY) && !pause && timer_zero &&
                 (GAP_CYCLES != '0)) begin
      timer_load = 1'b1;
      timer_val  = GAP_CYCLES - 28'd1;
    end
    timer_en = timing_state && !pause;
    mem_rd   = (state_q == ST_FETCH);
    busy     = (state_q != ST_IDLE);
    // pause mutes at once but keeps the pitch, so release resumes the note.
    tone_en  = tone_q && !(pause && timing_state);
  end

  assign mem_addr = mem_addr_q;
  assign beat     = beat_q;
  assign pitch    = pitch_q;
  assign done     = done_q;
  assign note_idx = note_idx_q;

endmodule

// File: tb/tb_score_sequencer.sv
// tb_score_sequencer
//   This bench models the score memory and the beat decoder. A reference
//   model builds the expected cycle-by-cycle outputs from the note list:
//   - 4 silent set-up cycles per note
//   - D sounding cycles
//   - GAP muted cycles
//   The bench compares the DUT against that list for directed and
//   randomized scores.
module tb_score_sequencer;

  localparam int GAP     = 3;
  localparam int PAT_LEN = 512;

  logic        clk = 1'b0;
  logic        RSTn = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        pause = 1'b0;
  logic        loop_en = 1'b0;
  logic [7:0]  base_addr = 8'h00;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata = 16'h0000;
  logic [3:0]  beat;
  logic [27:0] beat_cnt_parameter;
  logic [7:0]  pitch;
  logic        tone_en;
  logic        busy;
  logic        done;
  logic [7:0]  note_idx;

  logic [15:0] mem [256];
  logic [27:0] durTab [16];
  bit          pausePat [PAT_LEN];

  typedef struct packed {
    logic       b;
    logic       rd;
    logic [7:0] addr;
    logic       tone;
    logic [7:0] pitch;
    logic       dn;
    logic       play;
    logic [7:0] idx;
  } rec_t;

  rec_t expQ[$];

  int assertCount = 0;
  int failCount   = 0;

  score_sequencer #(
    .ADDR_W     (8),
    .GAP_CYCLES (28'd3),
    .END_WORD   (16'hFFFF)
  ) dut (
    .clk                (clk),
    .RSTn               (RSTn),
    .start              (start),
    .stop               (stop),
    .pause              (pause),
    .loop_en            (loop_en),
    .base_addr          (base_addr),
    .mem_addr           (mem_addr),
    .mem_rd             (mem_rd),
    .mem_rdata          (mem_rdata),
    .beat               (beat),
    .beat_cnt_parameter (beat_cnt_parameter),
    .pitch              (pitch),
    .tone_en            (tone_en),
    .busy               (busy),
    .done               (done),
    .note_idx           (note_idx)
  );

  always #5 clk = ~clk;

  // The score memory: read data is valid in the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  assign beat_cnt_parameter = durTab[beat];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    assertCount++;
    if (obs !== expv) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clearPause();
    for (int k = 0; k < PAT_LEN; k++) pausePat[k] = 1'b0;
  endtask

  // This is the reference model. It walks the score note by note:
  // - 3 set-up cycles, then END handling (done, or restart when looping)
  // - or a 4th set-up cycle, then D sounding cycles and GAP muted cycles
  // A paused PLAY/GAP cycle does not use up duration. After stop, every
  // cycle is idle.
  task automatic buildExpected(input logic [7:0] base, input bit loopEn,
                               input int nCycles, input int stopAt);
    rec_t        r;
    logic [7:0]  a;
    logic [15:0] w;
    int          rem;
    bit          finished;
    expQ.delete();
    expQ.push_back('0);
    a = base;
    finished = 1'b0;
    while (!finished && expQ.size() <= nCycles) begin
      w = mem[a];
      r = '0; r.b = 1'b1; r.rd = 1'b1; r.addr = a;
      expQ.push_back(r);
      r = '0; r.b = 1'b1;
      expQ.push_back(r);
      expQ.push_back(r);
      if (w == 16'hFFFF) begin
        if (loopEn) a = base;
        else begin
          r = '0; r.dn = 1'b1;
          expQ.push_back(r);
          finished = 1'b1;
        end
      end else begin
        expQ.push_back(r);
        rem = int'(durTab[w[15:12]]);
        if (rem != 0) begin
          while (rem > 0 && expQ.size() <= nCycles) begin
            r = '0; r.b = 1'b1; r.pitch = w[7:0]; r.play = 1'b1; r.idx = a;
            if (!pausePat[expQ.size()]) begin
              r.tone = (w[7:0] != 8'h00);
              rem--;
            end
            expQ.push_back(r);
          end
          rem = GAP;
          while (rem > 0 && expQ.size() <= nCycles) begin
            r = '0; r.b = 1'b1;
            if (!pausePat[expQ.size()]) rem--;
            expQ.push_back(r);
          end
        end
        a = a + 8'd1;
      end
    end
    while (expQ.size() <= nCycles) expQ.push_back('0);
    if (stopAt >= 0) begin
      for (int k = stopAt + 1; k <= nCycles; k++) expQ[k] = '0;
    end
  endtask

  // Start the score in cycle 0, then compare every cycle up to nCycles
  // against the model. Random starts are injected only where the model
  // expects the sequencer to be busy, so they must be ignored.
  task automatic applyStimulus(input string name, input logic [7:0] base, input bit loopEn,
                               input int nCycles, input int stopAt, input bit injectStarts,
                               output int toneHigh, output int doneCnt);
    rec_t obs;
    int   expTone;
    int   expDone;
    buildExpected(base, loopEn, nCycles, stopAt);
    toneHigh = 0; doneCnt = 0; expTone = 0; expDone = 0;
    base_addr = base;
    loop_en   = loopEn;
    for (int k = 0; k <= nCycles; k++) begin
      @(posedge clk); #1;
      start = (k == 0) || (injectStarts && expQ[k].b && (stopAt < 0 || k < stopAt) &&
                           ($urandom_range(0, 9) == 0));
      stop  = (k == stopAt);
      pause = pausePat[k];
      @(negedge clk);
      obs       = '0;
      obs.b     = busy;
      obs.rd    = mem_rd;
      obs.addr  = mem_rd ? mem_addr : 8'h00;
      obs.tone  = tone_en;
      obs.pitch = pitch;
      obs.dn    = done;
      obs.play  = expQ[k].play;
      obs.idx   = expQ[k].play ? note_idx : 8'h00;
      checkOutput($sformatf("%s cyc%0d", name, k), {3'b000, obs}, {3'b000, expQ[k]});
      toneHigh += int'(tone_en);
      doneCnt  += int'(done);
      expTone  += int'(expQ[k].tone);
      expDone  += int'(expQ[k].dn);
    end
    checkOutput({name, " toneCycles"}, toneHigh, expTone);
    checkOutput({name, " doneCount"}, doneCnt, expDone);
    @(posedge clk); #1;
    start = 1'b0; pause = 1'b0; stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " mem_addr"}, mem_addr, 0);
    checkOutput({tag, " mem_rd"}, mem_rd, 0);
    checkOutput({tag, " beat"}, beat, 0);
    checkOutput({tag, " pitch"}, pitch, 0);
    checkOutput({tag, " tone_en"}, tone_en, 0);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " done"}, done, 0);
    checkOutput({tag, " note_idx"}, note_idx, 0);
  endtask

  task automatic setBasic();
    for (int i = 0; i < 256; i++) mem[i] = 16'hFFFF;
    for (int i = 0; i < 16; i++) durTab[i] = 28'd0;
    durTab[0] = 28'd10;
    durTab[2] = 28'd5;
    mem[0] = 16'h0140;
    mem[1] = 16'h2041;
    mem[2] = 16'hFFFF;
  endtask

  initial begin
    logic [7:0]  rb;
    logic [15:0] w;
    int          len;
    bit          lp;
    int          stp;
    int          th;
    int          dc;

    clearPause();
    setBasic();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk); #1;
    RSTn = 1'b1;

    $display("[TB] basic playback");
    applyStimulus("basic", 8'h00, 1'b0, 40, -1, 1'b0, th, dc);
    checkOutput("basic toneTotal", th, 15);
    checkOutput("basic donePulses", dc, 1);

    $display("[TB] loop");
    applyStimulus("loop", 8'h00, 1'b1, 80, -1, 1'b0, th, dc);
    checkOutput("loop donePulses", dc, 0);

    $display("[TB] illegal beat and rest");
    mem[8'h10] = 16'h7040;
    mem[8'h11] = 16'h0100;
    mem[8'h12] = 16'h0155;
    mem[8'h13] = 16'hFFFF;
    applyStimulus("skiprest", 8'h10, 1'b0, 50, -1, 1'b0, th, dc);
    checkOutput("skiprest toneTotal", th, 10);

    $display("[TB] pause");
    mem[8'h20] = 16'h0140;
    mem[8'h21] = 16'hFFFF;
    for (int k = 10; k <= 16; k++) pausePat[k] = 1'b1;
    applyStimulus("pause", 8'h20, 1'b0, 40, -1, 1'b0, th, dc);
    checkOutput("pause toneTotal", th, 10);
    clearPause();

    $display("[TB] stop mid-note");
    applyStimulus("stop", 8'h20, 1'b0, 20, 7, 1'b0, th, dc);
    checkOutput("stop donePulses", dc, 0);

    $display("[TB] address wrap");
    mem[8'hFF] = 16'h0130;
    mem[8'h00] = 16'h2031;
    mem[8'h01] = 16'hFFFF;
    applyStimulus("wrap", 8'hFF, 1'b0, 40, -1, 1'b0, th, dc);

    $display("[TB] start/stop collision");
    applyStimulus("collide", 8'h20, 1'b0, 8, 0, 1'b0, th, dc);
    checkOutput("collide toneTotal", th, 0);

    $display("[TB] reset during gap");
    setBasic();
    base_addr = 8'h00;
    loop_en   = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    checkOutput("gap busy", busy, 1);
    checkOutput("gap tone_en", tone_en, 0);
    checkOutput("gap pitch", pitch, 0);
    RSTn = 1'b0;
    @(posedge clk); #1;
    RSTn = 1'b1;
    @(negedge clk);
    checkAllZero("midreset");
    applyStimulus("replay", 8'h00, 1'b0, 40, -1, 1'b0, th, dc);

    $display("[TB] randomized scores");
    for (int s = 0; s < 10; s++) begin
      for (int i = 0; i < 256; i++) mem[i] = 16'hFFFF;
      rb  = 8'($urandom_range(0, 255));
      len = int'($urandom_range(1, 5));
      for (int i = 0; i < len; i++) begin
        w[15:12] = 4'($urandom_range(0, 9));
        w[11:8]  = 4'($urandom);
        w[7:0]   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        mem[8'(rb + 8'(i))] = w;
      end
      mem[8'(rb + 8'(len))] = 16'hFFFF;
      for (int b = 0; b < 16; b++) durTab[b] = (b <= 6) ? 28'($urandom_range(1, 6)) : 28'd0;
      for (int k = 0; k < PAT_LEN; k++) pausePat[k] = ($urandom_range(0, 7) == 0);
      lp  = ($urandom_range(0, 3) == 0);
      stp = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 60)) : -1;
      applyStimulus($sformatf("rnd%0d", s), rb, lp, 150, stp, 1'b1, th, dc);
    end
    clearPause();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #1000000;
    failCount++;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
